core_mem_dresp: RTL and testbench



---
 rtl/core_common.sv | 21 ++
 rtl/core_mem_dresp_ram.sv | 37 +++
 rtl/core_mem_dresp.sv | 125 ++++++++++++
 tb/tb_core_mem_dresp.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/core_common.sv
//==============================================================================
// Module      : core_common (package)
// Description : Shared widths and dmem responder state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package core_common;

   localparam int unsigned c_data_w = 64;
   localparam int unsigned c_addr_w = 64;
   localparam int unsigned c_strb_w = 8;

   typedef enum logic [0:0] {
      DRESP_IDLE = 1'b0,
      DRESP_WAIT = 1'b1
   } dresp_state_t;

endpackage

`default_nettype wire

// File: rtl/core_mem_dresp_ram.sv
//==============================================================================
// Module      : core_mem_dresp_ram
// Description : Word array, asynchronous read, byte-strobed synchronous write.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module core_mem_dresp_ram
   import core_common::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096
) (
   input  logic                           g_clk,
   input  logic                           we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
   input  logic [c_strb_w-1:0]            strb,
   input  logic [c_data_w-1:0]            wdata,
   output logic [c_data_w-1:0]            rdata
);

   logic [c_data_w-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge g_clk) begin
      if (we) begin
         for (int i = 0; i < int'(c_strb_w); i++) begin
            if (strb[i]) begin
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = mem[idx];

endmodule

`default_nettype wire

// File: rtl/core_mem_dresp.sv
//==============================================================================
// Module      : core_mem_dresp
// Description : Data-memory responder for the dmem request/grant interface.
//               Optional random stall via CORE_DMEM_RAND_STALL_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module core_mem_dresp
   import core_common::*;
#(
   parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned MAX_STALL   = 3,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                g_clk,
   input  logic                g_resetn,
   input  logic                dmem_req,
   input  logic [c_addr_w-1:0] dmem_addr,
   input  logic                dmem_wen,
   input  logic [c_strb_w-1:0] dmem_strb,
   input  logic [c_data_w-1:0] dmem_wdata,
   output logic                dmem_gnt,
   output logic                dmem_err,
   output logic [c_data_w-1:0] dmem_rdata,
   output logic                proto_err
);

   localparam int unsigned   IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned   CNT_W = 16;
   localparam logic [63:0]   SPAN  = 64'(DEPTH_WORDS) * 64'd8;

   dresp_state_t         r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0]     w_stall;
   logic                 w_gnt, w_viol, w_in_range, w_we;
   logic [c_addr_w-1:0]  w_addr_al, w_offset;
   logic [c_data_w-1:0]  w_ram_rdata;
   logic                 unused_ok;

   // Offset wraps for addresses below BASE_ADDR, so both bounds are tested.
   assign w_addr_al  = {dmem_addr[c_addr_w-1:3], 3'b000};
   assign w_offset   = w_addr_al - BASE_ADDR;
   assign w_in_range = (w_addr_al >= BASE_ADDR) && (w_offset < SPAN);

`ifdef CORE_DMEM_RAND_STALL_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= {1'b0, r_lfsr[15:1]} ^ ({16{r_lfsr[0]}} & 16'hB400);
      end
   end

   assign w_stall   = CNT_W'(r_lfsr[3:0] & 4'(MAX_STALL));
   assign unused_ok = ^{dmem_addr[2:0], 32'(WAIT_CYCLES)};
`else
   assign w_stall   = CNT_W'(WAIT_CYCLES);
   assign unused_ok = ^{dmem_addr[2:0], LFSR_SEED, 32'(MAX_STALL)};
`endif

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         r_state   <= DRESP_IDLE;
         r_cnt     <= '0;
         proto_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         proto_err <= proto_err | w_viol;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_gnt       = 1'b0;
      w_viol      = 1'b0;
      case (r_state)
         DRESP_IDLE: begin
            if (dmem_req) begin
               w_state_nxt = DRESP_WAIT;
               w_cnt_nxt   = w_stall;
            end
         end
         DRESP_WAIT: begin
            if (!dmem_req) begin
               w_viol      = 1'b1;
               w_state_nxt = DRESP_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               // Grant is suppressed while reset is held so no write can land.
               w_gnt       = g_resetn;
               w_state_nxt = DRESP_IDLE;
            end
         end
         default: w_state_nxt = DRESP_IDLE;
      endcase
   end

   assign w_we       = w_gnt & w_in_range & dmem_wen;
   assign dmem_gnt   = w_gnt;
   assign dmem_err   = w_gnt & ~w_in_range;
   assign dmem_rdata = (w_gnt & w_in_range) ? w_ram_rdata : '0;

   core_mem_dresp_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .g_clk (g_clk),
      .we    (w_we),
      .idx   (w_offset[IDX_W+2:3]),
      .strb  (dmem_strb),
      .wdata (dmem_wdata),
      .rdata (w_ram_rdata)
   );

endmodule

`default_nettype wire

// File: tb/tb_core_mem_dresp.sv
//==============================================================================
// Module      : tb_core_mem_dresp
// Description : Self-checking bench for core_mem_dresp (WAIT_CYCLES 1 and 3).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_core_mem_dresp;

   localparam logic [63:0] BASE = 64'h8000_0000;
   localparam logic [63:0] SIZE = 64'd4096 * 64'd8;

   logic        g_clk = 1'b0;
   logic        g_resetn = 1'b0;
   logic        req   [2];
   logic [63:0] addr  [2];
   logic        wen   [2];
   logic [7:0]  strb  [2];
   logic [63:0] wdata [2];
   logic        gnt   [2];
   logic        err   [2];
   logic [63:0] rdata [2];
   logic        perr  [2];

   int total = 0;
   int bad   = 0;
   int hist [5];
   logic [63:0] last_rd;
   logic [63:0] model0 [int];
   logic [63:0] model1 [int];

   always #5 g_clk = ~g_clk;

   core_mem_dresp #(.WAIT_CYCLES(1)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn), .dmem_req(req[0]), .dmem_addr(addr[0]),
      .dmem_wen(wen[0]), .dmem_strb(strb[0]), .dmem_wdata(wdata[0]),
      .dmem_gnt(gnt[0]), .dmem_err(err[0]), .dmem_rdata(rdata[0]), .proto_err(perr[0]));

   core_mem_dresp #(.WAIT_CYCLES(3)) dut_w3 (
      .g_clk(g_clk), .g_resetn(g_resetn), .dmem_req(req[1]), .dmem_addr(addr[1]),
      .dmem_wen(wen[1]), .dmem_strb(strb[1]), .dmem_wdata(wdata[1]),
      .dmem_gnt(gnt[1]), .dmem_err(err[1]), .dmem_rdata(rdata[1]), .proto_err(perr[1]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: flat word map keyed by word number, updated byte by byte.
   task automatic txn(input int sel, input logic [63:0] a, input bit w,
                      input logic [7:0] s, input logic [63:0] d, input string tag);
      int          lat = 0;
      logic [63:0] aal, old, nw;
      bit          in_r, known;
      int          idx;
      @(negedge g_clk);
      req[sel] = 1'b1; addr[sel] = a; wen[sel] = w; strb[sel] = s; wdata[sel] = d;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge g_clk);
         if (gnt[sel] === 1'b1) lat = k;
      end
      if (lat == 0) begin
         chk({tag, "_timeout"}, 64'd0, 64'd1);
         req[sel] = 1'b0;
         return;
      end
`ifdef CORE_DMEM_RAND_STALL_EN
      chk({tag, "_lat"}, 64'(lat >= 1 && lat <= 4), 64'd1);
      if (lat <= 4) hist[lat]++;
`else
      chk({tag, "_lat"}, 64'(lat), (sel == 1) ? 64'd4 : 64'd2);
`endif
      aal  = {a[63:3], 3'b000};
      in_r = (aal >= BASE) && (aal < BASE + SIZE);
      idx  = int'((aal - BASE) >> 3);
      last_rd = rdata[sel];
      chk({tag, "_err"}, 64'(err[sel]), 64'(!in_r));
      known = in_r && ((sel == 0) ? model0.exists(idx) : model1.exists(idx));
      old   = known ? ((sel == 0) ? model0[idx] : model1[idx]) : 64'd0;
      if (!in_r) chk({tag, "_rd"}, rdata[sel], 64'd0);
      else if (known) chk({tag, "_rd"}, rdata[sel], old);
      if (w && in_r && (known || s == 8'hFF)) begin
         nw = old;
         for (int b = 0; b < 8; b++) if (s[b]) nw[8*b +: 8] = d[8*b +: 8];
         if (sel == 0) model0[idx] = nw; else model1[idx] = nw;
      end
      @(posedge g_clk);
      #1 req[sel] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          pool [32];
      int          done;
      logic [63:0] a;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; addr[i] = '0; wen[i] = 1'b0; strb[i] = '0; wdata[i] = '0;
      end
      for (int i = 0; i < 5; i++) hist[i] = 0;

      // Reset state.
      g_resetn = 1'b0;
      repeat (3) @(posedge g_clk);
      @(negedge g_clk);
      chk("rst_gnt", 64'(gnt[0]), 64'd0);
      chk("rst_err", 64'(err[0]), 64'd0);
      chk("rst_rdata", rdata[0], 64'd0);
      chk("rst_perr", 64'(perr[0]), 64'd0);
      chk("rst_perr3", 64'(perr[1]), 64'd0);
      g_resetn = 1'b1;

      // Write then read, partial strobe.
      txn(0, 64'h8000_0010, 1, 8'hFF, 64'h1122334455667788, "wr1");
      txn(0, 64'h8000_0010, 0, 8'h00, 64'h0, "rd1");
      chk("rd1_const", last_rd, 64'h1122334455667788);
      txn(0, 64'h8000_0010, 1, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, "wr2");
      chk("wr2_pre", last_rd, 64'h1122334455667788);
      txn(0, 64'h8000_0014, 0, 8'h00, 64'h0, "rd2");
      chk("rd2_const", last_rd, 64'h11223344AAAAAAAA);

      // Out of range, with neighbours and the aliasing word primed.
      txn(0, 64'h8000_7FF8, 1, 8'hFF, 64'hDEAD_BEEF_0000_7FF8, "wr_top");
      txn(0, 64'h8000_0000, 1, 8'hFF, 64'h0123_4567_89AB_CDEF, "wr_bot");
      txn(0, 64'h7FFF_FFF8, 0, 8'h00, 64'h0, "oor_rd");
      txn(0, 64'h8000_8000, 1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, "oor_wr");
      txn(0, 64'h8000_7FF8, 0, 8'h00, 64'h0, "rd_top");
      chk("rd_top_const", last_rd, 64'hDEAD_BEEF_0000_7FF8);
      txn(0, 64'h8000_0000, 0, 8'h00, 64'h0, "rd_bot");
      chk("rd_bot_const", last_rd, 64'h0123_4567_89AB_CDEF);

      // Reset during the stall of a write.
      txn(0, 64'h8000_0100, 1, 8'hFF, 64'hC0FF_EE00_C0FF_EE00, "wr_rst");
      @(negedge g_clk);
      req[0] = 1'b1; addr[0] = 64'h8000_0100; wen[0] = 1'b1; strb[0] = 8'hFF;
      wdata[0] = 64'h5555_5555_5555_5555;
      @(negedge g_clk);
`ifndef CORE_DMEM_RAND_STALL_EN
      chk("rst_wait_gnt", 64'(gnt[0]), 64'd0);
`endif
      g_resetn = 1'b0; req[0] = 1'b0;
      #1 chk("rst_hold_gnt", 64'(gnt[0]), 64'd0);
      @(posedge g_clk);
      #1 g_resetn = 1'b1;
      @(negedge g_clk);
      chk("rst_after_gnt", 64'(gnt[0]), 64'd0);
      chk("rst_after_perr", 64'(perr[0]), 64'd0);
      txn(0, 64'h8000_0100, 0, 8'h00, 64'h0, "rd_rst");
      chk("rd_rst_const", last_rd, 64'hC0FF_EE00_C0FF_EE00);

      // Protocol violation on the WAIT_CYCLES=3 instance.
      txn(1, 64'h8000_0200, 1, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD, "wr_pv");
      done = 0;
      for (int t = 0; t < 8 && done == 0; t++) begin
         @(negedge g_clk);
         req[1] = 1'b1; addr[1] = 64'h8000_0200; wen[1] = 1'b1; strb[1] = 8'hFF;
         wdata[1] = 64'h7777_7777_7777_7777;
         @(negedge g_clk);
`ifndef CORE_DMEM_RAND_STALL_EN
         chk("pv_early_gnt", 64'(gnt[1]), 64'd0);
`endif
         if (gnt[1] === 1'b1) begin
            model1[64] = 64'h7777_7777_7777_7777;
            @(posedge g_clk);
            #1 req[1] = 1'b0;
         end else begin
            req[1] = 1'b0;
            done = 1;
         end
      end
      chk("pv_attempt", 64'(done), 64'd1);
      for (int t = 0; t < 5; t++) begin
         @(negedge g_clk);
         chk($sformatf("pv_gnt%0d", t), 64'(gnt[1]), 64'd0);
         chk($sformatf("pv_perr%0d", t), 64'(perr[1]), 64'd1);
      end
      txn(1, 64'h8000_0200, 0, 8'h00, 64'h0, "rd_pv");
      chk("pv_sticky", 64'(perr[1]), 64'd1);
      chk("pv_other", 64'(perr[0]), 64'd0);

      // Randomized traffic against the reference map.
      for (int i = 0; i < 32; i++) begin
         pool[i] = int'($urandom_range(0, 4095));
         txn(0, BASE + 64'(pool[i]) * 8, 1, 8'hFF, {$urandom, $urandom}, "rnd_init");
      end
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 7) == 0)
            a = ($urandom_range(0, 1) != 0) ? BASE + SIZE + 64'($urandom_range(0, 255)) * 8
                                            : BASE - 8 - 64'($urandom_range(0, 255)) * 8;
         else
            a = BASE + 64'(pool[$urandom_range(0, 31)]) * 8 + 64'($urandom_range(0, 7));
         txn(0, a, $urandom_range(0, 1) != 0, 8'($urandom), {$urandom, $urandom}, "rnd_mix");
      end
      for (int i = 0; i < 1000; i++) begin
         a = BASE + 64'(pool[$urandom_range(0, 31)]) * 8 + 64'($urandom_range(0, 7));
         txn(0, a, 1'b0, 8'h00, 64'h0, "rnd_rd");
      end
`ifdef CORE_DMEM_RAND_STALL_EN
      for (int l = 1; l <= 4; l++) chk($sformatf("hist_lat%0d", l), 64'(hist[l] > 0), 64'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
